// File: rtl/mld_checksum_sequencer.sv
// mld_checksum_sequencer
//   Serial majority-logic decoder sequencer. It shifts an N-bit received word
//   in MSB first and presents six orthogonal check-sums to an external 6-input
//   majority gate. It rotates the word N times, flipping the MSB whenever the
//   gate votes 1, and then shifts the corrected word out MSB first.
//
// Parameters
//   N          codeword length in bits (3..63)
//   CHK0..CHK5 N-bit participation masks, bit i set -> buffer bit i in sum k
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      begin a new codeword (honoured only when idle)
//   din        serial received bit, MSB first
//   din_valid  din qualifier (ignored when idle)
//   maj_in     majority-gate result, combinational from chk
//   chk        check-sums to the majority gate (zero outside decode)
//   chk_valid  chk meaningful this cycle
//   dout       serial corrected bit, MSB first (zero outside unload)
//   dout_valid dout qualifier
//   busy       high whenever not idle
//   done       one-cycle pulse at end of word
//   ncorr      number of bits corrected in the last word (saturates at N)
module mld_checksum_sequencer #(
  parameter int           N    = 7,
  parameter logic [N-1:0] CHK0 = {N{1'b0}},
  parameter logic [N-1:0] CHK1 = {N{1'b0}},
  parameter logic [N-1:0] CHK2 = {N{1'b0}},
  parameter logic [N-1:0] CHK3 = {N{1'b0}},
  parameter logic [N-1:0] CHK4 = {N{1'b0}},
  parameter logic [N-1:0] CHK5 = {N{1'b0}}
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     din,
  input  logic                     din_valid,
  input  logic                     maj_in,
  output logic [5:0]               chk,
  output logic                     chk_valid,
  output logic                     dout,
  output logic                     dout_valid,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(N+1)-1:0]   ncorr
);

  localparam int CW = $clog2(N+1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_UNLOAD = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
  localparam logic [CW-1:0] NCORR_MAX = CW'(N);
  localparam logic [CW-1:0] ONE_CW = CW'(1);

  logic [2:0]    state_r;
  logic [N-1:0]  data_r;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] ncorr_r;
  logic [5:0]    chk_s;

  // Even-parity helper: XOR-reduce of the masked buffer.
  function automatic logic parity_f(input logic [N-1:0] v);
    return ^v;
  endfunction

  // Sequencer state, shift buffer, bit counter and correction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      data_r  <= {N{1'b0}};
      cnt_r   <= {CW{1'b0}};
      ncorr_r <= {CW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r <= ST_LOAD;
            cnt_r   <= {CW{1'b0}};
            ncorr_r <= {CW{1'b0}};
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (din_valid) begin
            data_r <= {data_r[N-2:0], din};
            if (cnt_r == LAST_IDX) begin
              cnt_r   <= {CW{1'b0}};
              state_r <= ST_DECODE;
            end else begin
              cnt_r <= cnt_r + ONE_CW;
            end
          end else begin
            state_r <= ST_LOAD;
          end
        end
        ST_DECODE: begin
          // Rotate left, correcting the bit leaving the MSB; after N
          // rotations every bit is back in its loaded position.
          data_r <= {data_r[N-2:0], data_r[N-1] ^ maj_in};
          if (maj_in && (ncorr_r != NCORR_MAX)) begin
            ncorr_r <= ncorr_r + ONE_CW;
          end else begin
            ncorr_r <= ncorr_r;
          end
          if (cnt_r == LAST_IDX) begin
            cnt_r   <= {CW{1'b0}};
            state_r <= ST_UNLOAD;
          end else begin
            cnt_r <= cnt_r + ONE_CW;
          end
        end
        ST_UNLOAD: begin
          data_r <= {data_r[N-2:0], 1'b0};
          if (cnt_r == LAST_IDX) begin
            cnt_r   <= {CW{1'b0}};
            state_r <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + ONE_CW;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= {CW{1'b0}};
        end
      endcase
    end
  end

  // Check-sums go straight from the buffer so the external majority gate can
  // answer within the same decode cycle.
  always_comb begin
    chk_s = 6'b0;
    if (state_r == ST_DECODE) begin
      chk_s = {parity_f(data_r & CHK5), parity_f(data_r & CHK4),
               parity_f(data_r & CHK3), parity_f(data_r & CHK2),
               parity_f(data_r & CHK1), parity_f(data_r & CHK0)};
    end else begin
      chk_s = 6'b0;
    end
  end

  assign chk        = chk_s;
  assign chk_valid  = (state_r == ST_DECODE);
  assign dout_valid = (state_r == ST_UNLOAD);
  assign dout       = (state_r == ST_UNLOAD) ? data_r[N-1] : 1'b0;
  assign busy       = (state_r != ST_IDLE);
  assign done       = (state_r == ST_DONE);
  assign ncorr      = ncorr_r;

endmodule
